// File: rtl/cs_frame_packer.sv
// rtl/cs_frame_packer.sv - ping-pong symbol buffer and byte framer for compressed-sensing measurements
//
// Optional feature macro: CS_PACK_CHK_EN (appends an XOR checksum byte to every frame).
//
// Ports:
//   sys_clk      in   1  rising-edge clock
//   sys_reset    in   1  asynchronous active-low reset
//   meas_valid   in   1  one 4-bit measurement symbol per high cycle
//   meas_data    in   4  measurement symbol
//   out_data     out  8  framed byte stream (A5, seq, 24 payload bytes [, checksum])
//   out_valid    out  1  out_data valid
//   out_ready    in   1  downstream accept
//   frame_count  out  8  frames fully transmitted, wraps 255->0
//   overflow     out  1  sticky, a frame was dropped because its bank was still full
//   busy         out  1  reader FSM not idle
module cs_frame_packer (
    input  logic       sys_clk,
    input  logic       sys_reset,
    input  logic       meas_valid,
    input  logic [3:0] meas_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] frame_count,
    output logic       overflow,
    output logic       busy
);

    localparam logic [5:0] LAST_SYM  = 6'd47;
    localparam logic [4:0] LAST_BYTE = 5'd23;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_PAYLOAD,
        ST_CHK
    } state_t;

    // Symbol storage; contents are not reset, only the flags that qualify them.
    logic [3:0] mem [2][48];

    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;
    logic [5:0] idx;
    logic       drop;

    state_t     state;
    logic [4:0] bcnt;
    logic [7:0] seq;
`ifdef CS_PACK_CHK_EN
    logic [7:0] chk;
`endif

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------

    // The drop decision is made on symbol 0 from the live full flag and then
    // held in 'drop' for the remaining 47 symbols of the frame.
    logic discard;
    assign discard = (idx == 6'd0) ? full[wr_bank] : drop;

    logic set_full;
    assign set_full = meas_valid && (idx == LAST_SYM) && !discard;

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            idx      <= 6'd0;
            wr_bank  <= 1'b0;
            drop     <= 1'b0;
            overflow <= 1'b0;
        end else if (meas_valid) begin
            if (idx == 6'd0) begin
                drop <= full[wr_bank];
                if (full[wr_bank]) begin
                    overflow <= 1'b1;
                end
            end
            if (idx == LAST_SYM) begin
                idx <= 6'd0;
                // A dropped frame does not advance the bank pointer, so the
                // writer stays in step with the reader's ping-pong order.
                if (!discard) begin
                    wr_bank <= ~wr_bank;
                end
            end else begin
                idx <= idx + 6'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (meas_valid && !discard) begin
            mem[wr_bank][idx] <= meas_data;
        end
    end

    // ------------------------------------------------------------------
    // Full flags: writer sets, reader clears; the two always address
    // different banks, so both can take effect on the same edge.
    // ------------------------------------------------------------------
    logic clr_full;
    logic [1:0] set_mask;
    logic [1:0] clr_mask;

    always_comb begin
        clr_full = 1'b0;
`ifdef CS_PACK_CHK_EN
        if (state == ST_CHK && out_ready) begin
            clr_full = 1'b1;
        end
`else
        if (state == ST_PAYLOAD && bcnt == LAST_BYTE && out_ready) begin
            clr_full = 1'b1;
        end
`endif
    end

    always_comb begin
        set_mask = 2'b00;
        clr_mask = 2'b00;
        set_mask[wr_bank] = set_full;
        clr_mask[rd_bank] = clr_full;
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            full <= 2'b00;
        end else begin
            full <= (full | set_mask) & ~clr_mask;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------

    // Payload byte k = {sym[2k], sym[2k+1]}: even symbol in the high nibble.
    logic [4:0] next_bcnt;
    logic [7:0] next_byte;
    logic [7:0] first_byte;

    assign next_bcnt  = bcnt + 5'd1;
    assign next_byte  = {mem[rd_bank][{next_bcnt, 1'b0}], mem[rd_bank][{next_bcnt, 1'b1}]};
    assign first_byte = {mem[rd_bank][6'd0], mem[rd_bank][6'd1]};

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            busy        <= 1'b0;
            bcnt        <= 5'd0;
            seq         <= 8'h00;
            rd_bank     <= 1'b0;
            frame_count <= 8'h00;
`ifdef CS_PACK_CHK_EN
            chk         <= 8'h00;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (full[rd_bank]) begin
                        state     <= ST_SYNC;
                        out_valid <= 1'b1;
                        out_data  <= SYNC_BYTE;
                        busy      <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (out_ready) begin
                        state    <= ST_SEQ;
                        out_data <= seq;
                    end
                end
                ST_SEQ: begin
                    if (out_ready) begin
                        state    <= ST_PAYLOAD;
                        bcnt     <= 5'd0;
                        out_data <= first_byte;
`ifdef CS_PACK_CHK_EN
                        chk      <= seq;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    if (out_ready) begin
`ifdef CS_PACK_CHK_EN
                        chk <= chk ^ out_data;
                        if (bcnt == LAST_BYTE) begin
                            state    <= ST_CHK;
                            out_data <= chk ^ out_data;
                        end else begin
                            bcnt     <= next_bcnt;
                            out_data <= next_byte;
                        end
`else
                        if (bcnt == LAST_BYTE) begin
                            state       <= ST_IDLE;
                            out_valid   <= 1'b0;
                            out_data    <= 8'h00;
                            busy        <= 1'b0;
                            rd_bank     <= ~rd_bank;
                            seq         <= seq + 8'd1;
                            frame_count <= frame_count + 8'd1;
                        end else begin
                            bcnt     <= next_bcnt;
                            out_data <= next_byte;
                        end
`endif
                    end
                end
                ST_CHK: begin
`ifdef CS_PACK_CHK_EN
                    if (out_ready) begin
                        state       <= ST_IDLE;
                        out_valid   <= 1'b0;
                        out_data    <= 8'h00;
                        busy        <= 1'b0;
                        rd_bank     <= ~rd_bank;
                        seq         <= seq + 8'd1;
                        frame_count <= frame_count + 8'd1;
                    end
`else
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
`endif
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cs_frame_packer.sv
// tb/tb_cs_frame_packer.sv - table-driven scoreboard bench for cs_frame_packer
module tb_cs_frame_packer;

    logic       sys_clk = 1'b0;
    logic       sys_reset;
    logic       meas_valid;
    logic [3:0] meas_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] frame_count;
    logic       overflow;
    logic       busy;

    cs_frame_packer dut (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .meas_valid  (meas_valid),
        .meas_data   (meas_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_count (frame_count),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [191:0] syms;
        logic [7:0]   seq;
        logic [7:0]   chk;
    } vec_t;

    vec_t       vecs[3];
    logic [7:0] q[$];
    int         n_vec = 0;
    int         n_err = 0;
    bit         mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard consumer: every accepted byte must match the head of the queue.
    always @(negedge sys_clk) begin
        if (mon_en && sys_reset && out_valid && out_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL extra_byte got %0h expected none", out_data);
            end else begin
                logic [7:0] e;
                e = q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL stream_byte got %0h expected %0h", out_data, e);
                end
            end
        end
    end

    function automatic logic [191:0] pat(input int mode);
        logic [191:0] s;
        s = '0;
        for (int i = 0; i < 48; i++) begin
            case (mode)
                0: s[4*i +: 4] = 4'(i % 16);
                1: s[4*i +: 4] = 4'hF;
                2: s[4*i +: 4] = (i == 0) ? 4'hA : 4'h0;
                default: s[4*i +: 4] = 4'h5;
            endcase
        end
        return s;
    endfunction

    function automatic logic [7:0] model_chk(input logic [191:0] s, input logic [7:0] sq);
        logic [7:0] c;
        c = sq;
        for (int k = 0; k < 24; k++) begin
            c = c ^ {s[8*k +: 4], s[8*k+4 +: 4]};
        end
        return c;
    endfunction

    task automatic push_frame(input logic [191:0] s, input logic [7:0] sq, input logic [7:0] c);
        q.push_back(8'hA5);
        q.push_back(sq);
        for (int k = 0; k < 24; k++) begin
            q.push_back({s[8*k +: 4], s[8*k+4 +: 4]});
        end
`ifdef CS_PACK_CHK_EN
        q.push_back(c);
`else
        if (c === 8'hxx) q.push_back(8'h00);
`endif
    endtask

    task automatic write_frame(input logic [191:0] s);
        for (int i = 0; i < 48; i++) begin
            meas_valid = 1'b1;
            meas_data  = s[4*i +: 4];
            @(posedge sys_clk); #1;
        end
        meas_valid = 1'b0;
        meas_data  = 4'h0;
    endtask

    task automatic drain(input string name);
        int n;
        for (n = 0; n < 2000; n++) begin
            if (q.size() == 0 && !busy) break;
            @(posedge sys_clk); #1;
        end
        if (n == 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout got %0d expected 0 bytes left", name, q.size());
        end
    endtask

    initial begin
        vecs[0] = '{syms: pat(0), seq: 8'h00, chk: 8'h00};
        vecs[1] = '{syms: pat(1), seq: 8'h01, chk: 8'h01};
        vecs[2] = '{syms: pat(2), seq: 8'h02, chk: 8'hA2};

        sys_reset  = 1'b0;
        meas_valid = 1'b0;
        meas_data  = 4'h0;
        out_ready  = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        sys_reset = 1'b1;
        @(posedge sys_clk); #1;

        // Table: back-to-back frames with out_ready held high.
        for (int i = 0; i < 3; i++) begin
            push_frame(vecs[i].syms, vecs[i].seq, vecs[i].chk);
            write_frame(vecs[i].syms);
            check("lat_idle", 32'(out_valid), 32'd0);
            @(posedge sys_clk); #1;
            check("lat_sync_valid", 32'(out_valid), 32'd1);
            check("lat_sync_data", 32'(out_data), 32'hA5);
            drain("table");
            check("table_frame_count", 32'(frame_count), 32'(i + 1));
        end

        // Stall on payload byte 5 for 10 cycles.
        push_frame(pat(0), 8'h03, model_chk(pat(0), 8'h03));
        write_frame(pat(0));
        begin
            int n;
            for (n = 0; n < 100; n++) begin
                if (out_valid && out_data == 8'hAB) break;
                @(posedge sys_clk); #1;
            end
            check("stall_found", 32'(n < 100), 32'd1);
        end
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'hAB);
        end
        @(posedge sys_clk); #1;
        out_ready = 1'b1;
        drain("stall");
        check("stall_frame_count", 32'(frame_count), 32'd4);

        // Overflow: three frames with the sink stalled, the third is dropped.
        out_ready = 1'b0;
        push_frame(pat(0), 8'h04, model_chk(pat(0), 8'h04));
        push_frame(pat(1), 8'h05, model_chk(pat(1), 8'h05));
        write_frame(pat(0));
        write_frame(pat(1));
        check("ovf_before", 32'(overflow), 32'd0);
        write_frame(pat(2));
        check("ovf_set", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        drain("ovf");
        check("ovf_frame_count", 32'(frame_count), 32'd6);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // The frame after a drop must still flow normally.
        push_frame(pat(1), 8'h06, model_chk(pat(1), 8'h06));
        write_frame(pat(1));
        drain("post_ovf");
        check("post_ovf_frame_count", 32'(frame_count), 32'd7);

        // Reset during payload byte 10.
        mon_en = 1'b0;
        write_frame(pat(3));
        begin
            int n;
            for (n = 0; n < 100; n++) begin
                if (out_valid) break;
                @(posedge sys_clk); #1;
            end
            check("rst_mid_sync", 32'(n < 100), 32'd1);
        end
        repeat (12) begin
            @(posedge sys_clk); #1;
        end
        check("rst_mid_active", 32'(out_valid), 32'd1);
        sys_reset = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_data", 32'(out_data), 32'h00);
        check("rst_mid_fc", 32'(frame_count), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        @(posedge sys_clk); #1;
        sys_reset = 1'b1;
        mon_en = 1'b1;
        push_frame(pat(0), 8'h00, model_chk(pat(0), 8'h00));
        write_frame(pat(0));
        drain("after_rst");
        check("after_rst_frame_count", 32'(frame_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cs_frame_packer.md
CS_FRAME_PACKER -- requirements
Module: cs_frame_packer

Interface
REQ-001 The block SHALL have no parameters; fixed sizes are 48 symbols/frame, 4-bit symbols, 24 payload bytes/frame.
REQ-002 The block SHALL have port sys_clk  in  1  rising-edge clock.
REQ-003 The block SHALL have port sys_reset  in  1  reset, asynchronous, active-low; clock sys_clk.
REQ-004 The block SHALL have port meas_valid  in  1  measurement symbol strobe, one symbol per high cycle.
REQ-005 The block SHALL have port meas_data  in  4  measurement symbol from the compressed-sensing encoder.
REQ-006 The block SHALL have port out_data  out  8  framed byte stream.
REQ-007 The block SHALL have port out_valid  out  1  out_data valid.
REQ-008 The block SHALL have port out_ready  in  1  downstream accept; transfer occurs when out_valid && out_ready.
REQ-009 The block SHALL have port frame_count  out  8  frames fully transmitted, wraps 255->0.
REQ-010 The block SHALL have port overflow  out  1  sticky flag, a frame was dropped.
REQ-011 The block SHALL have port busy  out  1  high while the reader FSM is not IDLE.

Function
REQ-012 Write side SHALL hold two 48x4 banks (ping-pong), a full flag per bank, a write-bank pointer and a symbol index 0..47.
REQ-013 Each meas_valid cycle SHALL store meas_data at the current index of the write bank and increment the index; index 47 SHALL wrap to 0, set full[wr_bank] and toggle wr_bank on the same edge.
REQ-014 The write bank's full flag SHALL be sampled when index==0; if set, all 48 symbols of that frame SHALL be discarded (index still counts) and overflow SHALL be set.
REQ-015 Packing SHALL place even-index symbol in bits [7:4] and odd-index symbol in bits [3:0]; payload byte k = {sym[2k], sym[2k+1]}.
REQ-016 The reader FSM SHALL have states IDLE, SYNC, SEQ, PAYLOAD, CHK; IDLE->SYNC on the edge after full[rd_bank] is seen set.
REQ-017 SYNC SHALL present 0xA5, SEQ SHALL present the 8-bit sequence number, PAYLOAD SHALL present bytes 0..23 in order, CHK SHALL present the checksum.
REQ-018 Each non-IDLE state SHALL drive out_valid=1 and advance only on handshake; out_data SHALL remain stable while out_valid && !out_ready.
REQ-019 On the handshake of the final frame byte, the block SHALL clear full[rd_bank], toggle rd_bank, increment sequence and frame_count (mod 256), and return to IDLE.
REQ-020 Latency: with out_ready=1, SYNC SHALL be presented 1 cycle after the edge capturing symbol 47; one byte SHALL transfer per cycle thereafter.
REQ-021 Simultaneous writer full-set and reader full-clear SHALL both take effect (they always address different banks).
REQ-022 Writer and reader SHALL operate concurrently; writing bank B while bank A is transmitted SHALL not corrupt either.

Reset
REQ-023 Asserting sys_reset SHALL immediately force out_valid=0, out_data=0x00, frame_count=0, overflow=0, busy=0, sequence=0, both full flags=0, wr_bank=rd_bank=0, index=0, FSM=IDLE.
REQ-024 Reset mid-frame SHALL discard all buffered symbols; bank contents need not be cleared.

Configuration
REQ-025 With macro CS_PACK_CHK_EN defined, CHK SHALL be entered after PAYLOAD byte 23 and SHALL present XOR of the sequence byte and all 24 payload bytes (27 bytes/frame).
REQ-026 Without CS_PACK_CHK_EN, PAYLOAD byte 23 SHALL be the final byte and CHK SHALL be unreachable (26 bytes/frame).

Verification
REQ-027 Symbols 0,1,..,15 repeated 3x, out_ready=1 -> A5,00, then 01,23,45,67,89,AB,CD,EF three times, then 00 if CS_PACK_CHK_EN; frame_count=1.
REQ-028 Second frame of 48x 0xF -> A5,01, 24x FF, checksum 01 (with macro); frame_count=2.
REQ-029 out_ready held low 10 cycles while payload byte 5 is presented -> out_valid=1 and out_data unchanged all 10 cycles, no byte lost or duplicated.
REQ-030 Three frames written with out_ready=0 -> third frame dropped, overflow=1; release out_ready -> only seq 00 and 01 emitted, frame_count=2, overflow stays 1.
REQ-031 sys_reset pulsed during PAYLOAD byte 10 -> out_valid=0 immediately, busy=0; next complete frame emits seq 00 with correct payload.
